// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, idle line level and the default bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int   CLKS_PER_BIT_115200 = 868;
    localparam logic UART_IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the shared UART transmitter: per-requester req/data/ack plus line status.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        ack;
    logic [2:0]                grant_id;
    logic                      busy;
    logic                      tx;

    modport master (output req, data, input ack, grant_id, busy, tx);
    modport slave  (input req, data, output ack, grant_id, busy, tx);
endinterface

// File: rtl/uart_tx_arbiter_baud_tick_gen.sv
// Bit timer: tick marks the last cycle of every CLKS_PER_BIT-cycle bit period.
// Latency: first tick CLKS_PER_BIT cycles after restart; no backpressure, restart wins over counting.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter plus start/data/stop serializer sharing one UART TX line.
// Latency: ack and busy one edge after a request is seen in IDLE; frame (DATA_W+2)*CLKS_PER_BIT cycles.
// Backpressure: requesters hold req/data until ack; requests are ignored while busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int BAUD_CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    uart_state_e        state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         rr_q, rr_d;
    logic               busy_q, busy_d;

    logic                 restart;
    logic                 tick;
    logic [2*NUM_REQ-1:0] req_rot;
    logic [3:0]           win_sum;
    logic                 win_vld;
    logic [2:0]           win_idx;
    logic [2:0]           rr_next;
    logic [DATA_W-1:0]    win_data;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (BAUD_CNT_W)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Rotate so bit 0 is the requester at rr_q; the lowest set bit is the winner.
    always_comb begin
        req_rot = {bus.req, bus.req} >> rr_q;
        win_vld = 1'b0;
        win_sum = {1'b0, rr_q};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_vld = 1'b1;
                win_sum = {1'b0, rr_q} + 4'(k);
            end
        end
        if (win_sum >= 4'(NUM_REQ)) begin
            win_sum = win_sum - 4'(NUM_REQ);
        end
        win_idx = win_sum[2:0];
        rr_next = ((4'(win_idx) + 4'd1) >= 4'(NUM_REQ)) ? 3'd0 : win_idx + 3'd1;

        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == win_idx) begin
                win_data = bus.data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        ack_d     = '0;
        grant_d   = grant_q;
        rr_d      = rr_q;
        busy_d    = busy_q;
        restart   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ack_d[i] = (3'(i) == win_idx);
                    end
                    shreg_d   = win_data;
                    grant_d   = win_idx;
                    rr_d      = rr_next;
                    busy_d    = 1'b1;
                    restart   = 1'b1;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            ack_q     <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
        end
    end

    // Line level decodes straight from registered state, so reset forces idle-high at once.
    assign bus.tx = (state_q == START) ? ~UART_IDLE_LEVEL :
                    (state_q == DATA)  ? shreg_q[0]       : UART_IDLE_LEVEL;

    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit line between NUM_REQ requesters. Each requester offers a byte with a req/ack handshake. A round-robin arbiter picks one requester, and a start/data/stop serializer sends the byte. Bit timing comes from an internal clock-enable tick counter (no derived clocks), sized by default for 100 MHz / 115200 baud. The block sits between the on-chip byte producers (debug console, status reporter) and the board TX pin.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- DATA_W, 8: bits per character.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200).
- BAUD_CNT_W, 10: bit-timer width; must satisfy 2^BAUD_CNT_W > CLKS_PER_BIT.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: asynchronous, active-high reset.
- req, input, NUM_REQ: req[i] high means requester i has a byte pending.
- data, input, NUM_REQ*DATA_W: byte of requester i on data[i*DATA_W +: DATA_W].
- ack, output, NUM_REQ: one-cycle pulse; ack[i] means requester i's byte is latched.
- grant_id, output, 3: index of the requester being serviced; holds its value after the frame ends.
- busy, output, 1: high from the ack cycle through the last STOP cycle.
- tx, output, 1: serial line; idle high.

Behaviour:
- Reset values (asynchronous, effective immediately): tx=1, busy=0, ack=0, grant_id=0, state=IDLE, rr_ptr=0, bit timer=0, bit index=0.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If any req bit is high, pick the first set bit searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - In that same cycle: pulse ack[winner], latch data[winner] into the shift register, set grant_id=winner, set rr_ptr=(winner+1) mod NUM_REQ, set busy=1.
  - Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: DATA_W bits, LSB first, each held for CLKS_PER_BIT cycles. Go to STOP after bit DATA_W-1.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final stop cycle, busy drops to 0 on the next edge and next state is IDLE.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and restarts at 0 on entry to START.
  - The baud tick is the cycle where the timer equals CLKS_PER_BIT-1; all bit transitions happen on it.
  - The timer is not free-running, so there is no phase error relative to the grant.
- Frame timing:
  - A frame is (DATA_W+2)*CLKS_PER_BIT cycles; 8680 at the defaults.
  - Back-to-back frames are separated by exactly one IDLE cycle (tx=1).
- Handshake:
  - A requester holds req and data stable until it sees ack.
  - req sampled low in IDLE is never granted.
  - req changes while busy are ignored.
  - A requester may re-assert req in the cycle after its ack. Round-robin still gives the others priority.
- Simultaneous requests: at most one ack per cycle. With rr_ptr=0 and req=2'b11, requester 0 goes first and requester 1 next.
- Reset mid-frame: the frame is aborted, tx=1 immediately, and the in-flight byte is discarded. No ack is re-issued.
- Data after ack does not affect the transmitted byte.

Decomposition:
- A shared package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - CLKS_PER_BIT_115200=868;
  - the constant UART_IDLE_LEVEL=1.
- One sub-module, baud_tick_gen: a bit timer with inputs clk, rst and restart, and output tick. It is parameterised by CLKS_PER_BIT and reusable by a future UART receiver.
- The arbiter and serializer stay in uart_tx_arbiter.

Test Plan:
1. Reset: assert rst mid-bench → tx=1, busy=0, ack=0 within the same cycle, asynchronously.
2. Single byte with CLKS_PER_BIT=4: req[0]=1, data[7:0]=8'hA5 → one ack[0] pulse. tx reads 0 for 4 cycles, then LSB-first bits of A5 (1,0,1,0,0,1,0,1) each 4 cycles, then 1 for 4 cycles. busy is high for 40 cycles.
3. Contention: req=2'b11 from reset, bytes 8'h41 and 8'h42 → 0x41 sent first, then 0x42. There is exactly 1 idle cycle between the frames, and grant_id goes 0 then 1.
4. Fairness: requester 0 re-asserts immediately after every ack while requester 1 is held high → grants alternate 0,1,0,1 over 4 frames.
5. Data stability: change data[0] to 8'hFF the cycle after ack[0] → the line still carries the latched byte.
6. Reset mid-DATA (bit 3): assert rst 2 cycles → tx=1 and IDLE, no ack during reset. After release with req still high, a fresh ack and a full frame follow.
7. Default timing: CLKS_PER_BIT=868 → the start bit lasts exactly 868 cycles and the full frame 8680.
